program_loader: RTL
===================

PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter WORD_SIZE, 8, data-memory word width in bits.
REQ-002 Parameter ADDR_LEN, 8, data-memory address width.
REQ-003 Parameter MEM_SIZE, 256, data-memory depth in words.
REQ-004 Parameter INST_LEN, 12, instruction width in bits.
REQ-005 Parameter INST_CAP, 20, instruction-memory depth.
REQ-006 Port clk  input  1  single clock; all state changes on rising edge.
REQ-007 Port rstn  input  1  reset, asynchronous, active-low.
REQ-008 Port start  input  1  one-cycle pulse that begins a load session.
REQ-009 Port in_valid  input  1  source has a byte on in_data.
REQ-010 Port in_data  input  8  stream byte.
REQ-011 Port in_ready  output  1  loader accepts a byte; transfer occurs when in_valid and in_ready are both high.
REQ-012 Port inst_we  output  1  instruction-memory write strobe.
REQ-013 Port inst_addr  output  $clog2(INST_CAP)  instruction write address.
REQ-014 Port inst_wdata  output  INST_LEN  instruction write data.
REQ-015 Port mem_we  output  1  data-memory write strobe.
REQ-016 Port mem_addr  output  ADDR_LEN  data write address.
REQ-017 Port mem_wdata  output  WORD_SIZE  data write word.
REQ-018 Port cpu_rstn  output  1  active-low reset to the CPU; high only in DONE.
REQ-019 Port done  output  1  load finished successfully.
REQ-020 Port err  output  1  load aborted on a malformed stream.

Function
REQ-021 The FSM SHALL have the states IDLE, INST_CNT, INST_HI, INST_LO, DATA_CNT, DATA, DONE and ERROR.
REQ-022 Stream format SHALL be: N byte (instruction count); N pairs {HI byte, with bits [3:0] = inst[11:8] and bits [7:4] ignored; LO byte = inst[7:0]}; D byte (data count); D data bytes.
REQ-023 IDLE/DONE/ERROR + start -> INST_CNT; start in any other state SHALL be ignored.
REQ-024 In INST_CNT, an accepted N with 1<=N<=INST_CAP -> INST_HI; N=0 or N>INST_CAP -> ERROR.
REQ-025 INST_HI -> INST_LO on an accepted byte; INST_LO -> INST_HI on an accepted byte while fewer than N instructions have been written, otherwise -> DATA_CNT.
REQ-026 DATA_CNT, accepted D: D=0 -> DONE, otherwise -> DATA; DATA -> DONE after the D-th accepted byte.
REQ-027 in_ready SHALL be high exactly in INST_CNT, INST_HI, INST_LO, DATA_CNT and DATA.
REQ-028 inst_we SHALL pulse for one cycle in the cycle after an accepted LO byte, with inst_addr = 0,1,...,N-1 in order.
REQ-029 mem_we SHALL pulse for one cycle in the cycle after each accepted data byte, with mem_addr = 0,...,D-1 and mem_wdata = that byte.
REQ-030 Address/data outputs SHALL be registered and held between strobes; counters reset to 0 on entry to INST_CNT.
REQ-031 done = (state==DONE); err = (state==ERROR); cpu_rstn = (state==DONE), registered, with no glitch on state changes.
REQ-032 A restart from DONE SHALL drive cpu_rstn low in the cycle after start.
REQ-033 in_valid low SHALL stall the FSM indefinitely with no strobes.

Reset
REQ-034 rstn low SHALL asynchronously force IDLE, all counters 0, and in_ready, inst_we, mem_we, done, err and cpu_rstn all 0; all address/data outputs 0.
REQ-035 Reset mid-session SHALL abandon the session; no strobe is issued for a partially received instruction.

Structure
REQ-036 Package loader_pkg SHALL hold the state enum and the parameter defaults WORD_SIZE, ADDR_LEN, MEM_SIZE, INST_LEN and INST_CAP.
REQ-037 The block SHALL be a single module with no sub-modules; the FSM and counters are inline.

Verification
REQ-038 Stream 02,0A,BC,01,23,01,7F -> inst[0]=ABC, inst[1]=123, mem[0]=7F, then done=1 and cpu_rstn=1.
REQ-039 N=0x15 (21) -> err=1, cpu_rstn=0, no strobes, in_ready=0.
REQ-040 Stream 01,0F,FF,00 -> a single inst write FFF@0, no mem_we, DONE directly after D.
REQ-041 D=0xFF with random in_valid gaps -> 255 mem_we pulses at addresses 0..254 in order, with the data matching.
REQ-042 rstn low after an INST_HI byte, then a full reload -> no strobe for the aborted pair; the new load is correct.
REQ-043 start in DONE -> cpu_rstn falls the next cycle; the second session overwrites from address 0.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared definitions for the program loader: FSM state encoding and the
// default memory geometry used by the loader's parameters.
package loader_pkg;

    localparam int DEF_WORD_SIZE = 8;
    localparam int DEF_ADDR_LEN  = 8;
    localparam int DEF_MEM_SIZE  = 256;
    localparam int DEF_INST_LEN  = 12;
    localparam int DEF_INST_CAP  = 20;

    typedef enum logic [2:0] {
        IDLE,
        INST_CNT,
        INST_HI,
        INST_LO,
        DATA_CNT,
        DATA,
        DONE,
        ERROR
    } state_e;

endpackage

// File: rtl/program_loader.sv
// Byte-stream program loader: parses {N, N x (HI,LO), D, D x data} and writes
// instruction and data memories, then releases the CPU from reset.
module program_loader
    import loader_pkg::*;
#(
    parameter int WORD_SIZE = DEF_WORD_SIZE,
    parameter int ADDR_LEN  = DEF_ADDR_LEN,
    parameter int MEM_SIZE  = DEF_MEM_SIZE,
    parameter int INST_LEN  = DEF_INST_LEN,
    parameter int INST_CAP  = DEF_INST_CAP
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        start,
    input  logic                        in_valid,
    input  logic [7:0]                  in_data,
    output logic                        in_ready,
    output logic                        inst_we,
    output logic [$clog2(INST_CAP)-1:0] inst_addr,
    output logic [INST_LEN-1:0]         inst_wdata,
    output logic                        mem_we,
    output logic [ADDR_LEN-1:0]         mem_addr,
    output logic [WORD_SIZE-1:0]        mem_wdata,
    output logic                        cpu_rstn,
    output logic                        done,
    output logic                        err
);

    localparam int         IA_W  = $clog2(INST_CAP);
    localparam int         CNT_W = $clog2(INST_CAP + 1);
    localparam logic [7:0] CAP_B = 8'(INST_CAP);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     n_q, n_d, inst_idx_q, inst_idx_d;
    logic [3:0]           hi_q, hi_d;
    logic [7:0]           d_q, d_d, data_idx_q, data_idx_d;
    logic                 in_ready_q, in_ready_d;
    logic                 inst_we_q, inst_we_d;
    logic [IA_W-1:0]      inst_addr_q, inst_addr_d;
    logic [INST_LEN-1:0]  inst_wdata_q, inst_wdata_d;
    logic                 mem_we_q, mem_we_d;
    logic [ADDR_LEN-1:0]  mem_addr_q, mem_addr_d;
    logic [WORD_SIZE-1:0] mem_wdata_q, mem_wdata_d;
    logic                 done_q, done_d, err_q, err_d, cpu_rstn_q, cpu_rstn_d;
    logic                 take;

    // in_ready_q mirrors the accepting states, so it doubles as the handshake gate.
    assign take = in_valid && in_ready_q;

    always_comb begin
        state_d      = state_q;
        n_d          = n_q;
        inst_idx_d   = inst_idx_q;
        hi_d         = hi_q;
        d_d          = d_q;
        data_idx_d   = data_idx_q;
        inst_we_d    = 1'b0;
        inst_addr_d  = inst_addr_q;
        inst_wdata_d = inst_wdata_q;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;

        case (state_q)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    state_d    = INST_CNT;
                    n_d        = '0;
                    inst_idx_d = '0;
                    d_d        = '0;
                    data_idx_d = '0;
                end
            end
            INST_CNT: begin
                if (take) begin
                    if (in_data == 8'd0 || in_data > CAP_B) begin
                        state_d = ERROR;
                    end else begin
                        n_d     = CNT_W'(in_data);
                        state_d = INST_HI;
                    end
                end
            end
            INST_HI: begin
                if (take) begin
                    hi_d    = in_data[3:0];
                    state_d = INST_LO;
                end
            end
            INST_LO: begin
                if (take) begin
                    inst_we_d    = 1'b1;
                    inst_addr_d  = IA_W'(inst_idx_q);
                    inst_wdata_d = INST_LEN'({hi_q, in_data});
                    inst_idx_d   = inst_idx_q + 1'b1;
                    state_d      = (inst_idx_d < n_q) ? INST_HI : DATA_CNT;
                end
            end
            DATA_CNT: begin
                if (take) begin
                    d_d     = in_data;
                    state_d = (in_data == 8'd0) ? DONE : DATA;
                end
            end
            DATA: begin
                if (take) begin
                    // Bytes beyond the data memory are consumed but not written.
                    mem_we_d    = ({24'd0, data_idx_q} < 32'(MEM_SIZE));
                    mem_addr_d  = ADDR_LEN'(data_idx_q);
                    mem_wdata_d = WORD_SIZE'(in_data);
                    data_idx_d  = data_idx_q + 8'd1;
                    if ({1'b0, data_idx_q} + 9'd1 == {1'b0, d_q}) begin
                        state_d = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d = (state_d == INST_CNT) || (state_d == INST_HI) || (state_d == INST_LO) ||
                     (state_d == DATA_CNT) || (state_d == DATA);
        done_d     = (state_d == DONE);
        err_d      = (state_d == ERROR);
        cpu_rstn_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            n_q          <= '0;
            inst_idx_q   <= '0;
            hi_q         <= '0;
            d_q          <= '0;
            data_idx_q   <= '0;
            in_ready_q   <= 1'b0;
            inst_we_q    <= 1'b0;
            inst_addr_q  <= '0;
            inst_wdata_q <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            cpu_rstn_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            n_q          <= n_d;
            inst_idx_q   <= inst_idx_d;
            hi_q         <= hi_d;
            d_q          <= d_d;
            data_idx_q   <= data_idx_d;
            in_ready_q   <= in_ready_d;
            inst_we_q    <= inst_we_d;
            inst_addr_q  <= inst_addr_d;
            inst_wdata_q <= inst_wdata_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            done_q       <= done_d;
            err_q        <= err_d;
            cpu_rstn_q   <= cpu_rstn_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign inst_we    = inst_we_q;
    assign inst_addr  = inst_addr_q;
    assign inst_wdata = inst_wdata_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign done       = done_q;
    assign err        = err_q;
    assign cpu_rstn   = cpu_rstn_q;

endmodule
